pixel_invert_stream: RTL and testbench
======================================

# pixel_invert_stream

Synthesizable streaming stage that consumes a byte-serial, raster-ordered pixel stream (channel-interleaved, as delivered by the DPI PNG source in the bench) and emits the photographic negative (255 − byte) with frame/line framing tags. It sits between the DPI-driven pixel source and the DPI-driven pixel sink, replacing the behavioural inversion loop with RTL. Valid/ready on both sides, full throughput, 1-cycle latency.

## Interface
- MAX_DIM, 4096, max frame width and height in pixels.
- DIM_W, 16, width of dimension inputs and internal counters.

- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- cfg_width  in  DIM_W  pixels per line, 1..MAX_DIM; sampled on accepted start.
- cfg_height  in  DIM_W  lines per frame, 1..MAX_DIM; sampled on accepted start.
- cfg_channel  in  3  bytes per pixel, 1..4; sampled on accepted start.
- s_valid  in  1  input byte valid.
- s_ready  out  1  stage accepts input byte.
- s_data  in  8  input byte.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accepts output byte.
- m_data  out  8  output byte.
- m_sof  out  1  first byte of frame.
- m_eol  out  1  last byte of a line.
- m_eof  out  1  last byte of frame.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at frame completion.
- err  out  1  one-cycle pulse on rejected start.

## Operation
- States: IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE: start with all cfg values in range → latch cfg, clear counters, → RUN. Any cfg out of range (0, >MAX_DIM, channel 0 or >4) → err pulse, stay IDLE.
- RUN: s_ready = skid buffer not full. Each handshake (s_valid & s_ready) transforms byte, pushes it with tags, advances counters dpt (0..ch−1) → pxl (0..w−1) → line (0..h−1), each wrapping to 0 on carry.
- Tags: sof when line=pxl=dpt=0; eol when pxl=w−1 and dpt=ch−1; eof when eol and line=h−1.
- Acceptance of the eof byte → DRAIN; s_ready = 0 from the next cycle.
- DRAIN: when the buffer is empty, pulse done for one cycle, → IDLE.
- start outside IDLE is ignored (no err).
- s_ready = 0 in IDLE and DRAIN; input bytes offered there are neither consumed nor dropped.
- Transform: m_data = 8'hFF ^ s_data (identical to 255 − x for 8-bit).

## Timing
- Reset values: s_ready 0, m_valid 0, m_data 0, m_sof/m_eol/m_eof 0, busy 0, done 0, err 0; counters 0.
- Latency: byte accepted at cycle N appears on m_data at cycle N+1 (if buffer was empty).
- Throughput: 1 byte/cycle with m_ready held high; 2-entry skid buffer keeps s_ready registered (no combinational m_ready → s_ready path).
- m_valid/m_data/tags stay stable while m_valid & !m_ready.
- Simultaneous push and pop on a full buffer is legal; occupancy unchanged.
- done asserts the cycle after the eof byte handshakes on the output side; busy deasserts in the same cycle as done.
- Reset mid-frame: all state discarded immediately, buffered bytes lost, outputs return to reset values.

## Configuration
- PIXEL_INVERT_ALPHA_BYPASS_EN defined: when latched channel = 4, byte with dpt = 3 (alpha) passes unmodified; other channels inverted.
- Undefined: every byte inverted regardless of channel count.

## Structure
- Package pixel_stream_pkg: state enum (IDLE/RUN/DRAIN), byte-plus-tags struct {data, sof, eol, eof}, constants MAX_CHANNEL = 4, INVERT_MASK = 8'hFF.
- Sub-module pixel_skid_buffer: 2-entry valid/ready register slice over the tagged struct, with clk/reset_n.

## Test plan
- 2×2×3 frame, bytes 0..11, m_ready=1 → outputs 255..244, sof on byte 0, eol on bytes 5 and 11, eof on 11, done pulse once, 12 output cycles back-to-back.
- Same frame, m_ready toggled 1/0 every cycle → identical sequence, no loss/duplication, m_data stable while stalled.
- 1×1×4 frame bytes 10,20,30,40 → 245,235,225,215 without macro; 245,235,225,40 with PIXEL_INVERT_ALPHA_BYPASS_EN.
- start with cfg_width=0, then with cfg_channel=5 → err pulse each, busy stays 0, s_ready stays 0.
- reset_n low after 7 bytes of a 4×4×1 frame → all outputs 0 within same cycle; new frame after reset completes correctly with sof on first byte.
- start pulsed during RUN with different cfg → ignored, current frame tags/counts unchanged.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// Shared types for the pixel inversion stream: FSM states, tagged byte, constants.
// No logic; imported by the stage and its skid buffer.
// No flow control of its own.
package pixel_stream_pkg;

    localparam int         MAX_CHANNEL = 4;
    localparam logic [7:0] INVERT_MASK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } tagged_byte_t;

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry register slice carrying a data byte and its framing tags.
// Latency: 1 cycle from push to head. Backpressure: in_rdy = not full (registered occupancy).
// out_rdy never reaches in_rdy combinationally; out_dat is held while out_vld & !out_rdy.
module pixel_skid_buffer
    import pixel_stream_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  tagged_byte_t in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output tagged_byte_t out_dat
);

    tagged_byte_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    assign in_rdy  = (cnt != 2'd2);
    assign out_vld = (cnt != 2'd0);
    assign out_dat = out_vld ? mem[rd_ptr] : '0;
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pixel_invert_stream.sv
// Inverts a byte-serial raster pixel stream (255 - x) and tags sof/eol/eof; PIXEL_INVERT_ALPHA_BYPASS_EN passes alpha of 4-channel frames.
// Latency: 1 cycle through a 2-entry skid buffer, 1 byte/cycle sustained.
// Backpressure: s_ready is registered buffer-not-full, gated to RUN; held data stays stable while stalled.
module pixel_invert_stream
    import pixel_stream_pkg::*;
#(
    parameter int MAX_DIM = 4096,
    parameter int DIM_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic [2:0]       cfg_channel,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_eof,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);

    state_e           state_q, state_nxt;
    logic [DIM_W-1:0] w_last_q, h_last_q, ch_last_q;
    logic [DIM_W-1:0] dpt_q, pxl_q, line_q;
    logic             dpt_last, pxl_last, line_last;
    logic             cfg_ok, cfg_load, in_hs, buf_rdy;
    logic             done_nxt, err_nxt, done_q, err_q;
    logic [7:0]       mask;
    tagged_byte_t     push_dat, head_dat;

    assign cfg_ok = (cfg_width  != '0) && (cfg_width  <= DIM_MAX) &&
                    (cfg_height != '0) && (cfg_height <= DIM_MAX) &&
                    (cfg_channel != 3'd0) && (cfg_channel <= 3'(MAX_CHANNEL));

    assign s_ready = (state_q == RUN) && buf_rdy;
    assign in_hs   = s_valid && s_ready;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;

    // Counters hold the position of the byte currently offered, so tags come straight from them.
    assign dpt_last  = (dpt_q  == ch_last_q);
    assign pxl_last  = (pxl_q  == w_last_q);
    assign line_last = (line_q == h_last_q);

`ifdef PIXEL_INVERT_ALPHA_BYPASS_EN
    assign mask = ((ch_last_q == DIM_W'(MAX_CHANNEL - 1)) && (dpt_q == DIM_W'(3))) ? 8'h00 : INVERT_MASK;
`else
    assign mask = INVERT_MASK;
`endif

    assign push_dat.data = s_data ^ mask;
    assign push_dat.sof  = (dpt_q == '0) && (pxl_q == '0) && (line_q == '0);
    assign push_dat.eol  = dpt_last && pxl_last;
    assign push_dat.eof  = dpt_last && pxl_last && line_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cfg_load  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        cfg_load  = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (in_hs && push_dat.eof) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The eof byte is always the last one buffered; its output handshake empties the stage.
                if (!m_valid || (m_ready && m_eof)) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_last_q  <= '0;
            h_last_q  <= '0;
            ch_last_q <= '0;
            dpt_q     <= '0;
            pxl_q     <= '0;
            line_q    <= '0;
        end else if (cfg_load) begin
            w_last_q  <= cfg_width - DIM_W'(1);
            h_last_q  <= cfg_height - DIM_W'(1);
            ch_last_q <= DIM_W'(cfg_channel) - DIM_W'(1);
            dpt_q     <= '0;
            pxl_q     <= '0;
            line_q    <= '0;
        end else if (in_hs) begin
            if (dpt_last) begin
                dpt_q <= '0;
                if (pxl_last) begin
                    pxl_q  <= '0;
                    line_q <= line_last ? '0 : line_q + DIM_W'(1);
                end else begin
                    pxl_q <= pxl_q + DIM_W'(1);
                end
            end else begin
                dpt_q <= dpt_q + DIM_W'(1);
            end
        end
    end

    pixel_skid_buffer u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .in_vld  (in_hs),
        .in_rdy  (buf_rdy),
        .in_dat  (push_dat),
        .out_vld (m_valid),
        .out_rdy (m_ready),
        .out_dat (head_dat)
    );

    assign m_data = head_dat.data;
    assign m_sof  = head_dat.sof;
    assign m_eol  = head_dat.eol;
    assign m_eof  = head_dat.eof;

endmodule

// File: tb/tb_pixel_invert_stream.sv
// Bench for pixel_invert_stream: directed and random frames against a raster-loop reference model.
module tb_pixel_invert_stream;

    typedef struct packed {
        logic [7:0] dat;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

`ifdef PIXEL_INVERT_ALPHA_BYPASS_EN
    localparam bit ALPHA_BYPASS = 1'b1;
`else
    localparam bit ALPHA_BYPASS = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] cfg_width;
    logic [15:0] cfg_height;
    logic [2:0]  cfg_channel;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_sof;
    logic        m_eol;
    logic        m_eof;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    pixel_invert_stream #(.MAX_DIM(4096), .DIM_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .cfg_channel (cfg_channel),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_sof       (m_sof),
        .m_eol       (m_eol),
        .m_eof       (m_eof),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic bad_start(input string tag, input int w, input int h, input int ch);
        cfg_width   = 16'(w);
        cfg_height  = 16'(h);
        cfg_channel = 3'(ch);
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_err"}, err, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_s_ready"}, s_ready, 0);
        @(negedge clk);
        check({tag, "_err_single"}, err, 0);
    endtask

    // rmode: 0 m_ready high, 1 toggle, 2 random. vmode: 0 s_valid high, 1 random.
    // dmode: 0 random bytes, 1 byte k, 2 byte 10*(k+1).
    task automatic run_frame(input int w, input int h, input int ch, input int rmode, input int vmode,
                             input int dmode, input int abort_after, input bit mid_start);
        exp_t        exp_q[$];
        logic [7:0]  in_q[$];
        logic [7:0]  b;
        logic [11:0] held;
        int n, k, cyc, in_idx, out_idx, first_out, last_out, done_seen, err_seen;
        bit lat_pend, stalled, fin, hs, mid_done;

        k = 0;
        for (int li = 0; li < h; li++)
            for (int pi = 0; pi < w; pi++)
                for (int di = 0; di < ch; di++) begin
                    case (dmode)
                        1:       b = 8'(k);
                        2:       b = 8'(10 * (k + 1));
                        default: b = 8'($urandom_range(0, 255));
                    endcase
                    in_q.push_back(b);
                    exp_q.push_back('{dat: (ALPHA_BYPASS && ch == 4 && di == 3) ? b : 8'(255 - int'(b)),
                                      sof: (li == 0 && pi == 0 && di == 0),
                                      eol: (pi == w - 1 && di == ch - 1),
                                      eof: (pi == w - 1 && di == ch - 1 && li == h - 1)});
                    k++;
                end
        n = exp_q.size();

        cfg_width   = 16'(w);
        cfg_height  = 16'(h);
        cfg_channel = 3'(ch);
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("s_ready_after_start", s_ready, 1);

        cyc = 0; in_idx = 0; out_idx = 0; first_out = -1; last_out = -1;
        done_seen = 0; err_seen = 0; lat_pend = 0; stalled = 0; fin = 0; mid_done = 0;
        held = '0;
        while (!fin && cyc < 3000) begin
            if (lat_pend) begin
                check("latency_valid", m_valid, 1);
                check("latency_data", m_data, exp_q[0].dat);
                lat_pend = 0;
            end
            if (stalled) check("stall_stable", {m_valid, m_data, m_sof, m_eol, m_eof}, held);
            if (done) done_seen++;
            if (err) err_seen++;

            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2 == 0);
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
            stalled = m_valid && !m_ready;
            held    = {m_valid, m_data, m_sof, m_eol, m_eof};
            if (m_valid && m_ready) begin
                if (out_idx < n) check("out_byte", {m_data, m_sof, m_eol, m_eof}, exp_q[out_idx]);
                else check("extra_output", 1, 0);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                out_idx++;
                if (out_idx == n) fin = 1;
            end

            if (mid_start && !mid_done && in_idx == 3) begin
                start       = 1'b1;
                cfg_width   = 16'(w + 3);
                cfg_height  = 16'(h + 1);
                cfg_channel = (ch == 1) ? 3'd2 : 3'd1;
                mid_done    = 1;
            end else begin
                start = 1'b0;
            end

            if (abort_after >= 0 && in_idx == abort_after) begin
                s_valid = 1'b0;
                reset_n = 1'b0;
                #1;
                check("reset_mid_frame_outputs",
                      {s_ready, m_valid, m_data, m_sof, m_eol, m_eof, busy, done, err}, 0);
                @(negedge clk);
                reset_n = 1'b1;
                @(negedge clk);
                return;
            end

            if (in_idx < n) begin
                s_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                s_data  = in_q[in_idx];
            end else begin
                s_valid = 1'b1;
                s_data  = 8'($urandom_range(0, 255));
                check("no_accept_in_drain", s_ready, 0);
            end
            hs = s_valid && s_ready;
            @(posedge clk);
            if (hs) begin
                if (in_idx == 0) lat_pend = 1;
                in_idx++;
            end
            @(negedge clk);
            cyc++;
        end

        s_valid = 1'b0;
        start   = 1'b0;
        check("frame_timeout", fin, 1);
        check("frame_complete", out_idx, n);
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("s_ready_at_done", s_ready, 0);
        check("no_early_done", done_seen, 0);
        check("no_err_in_frame", err_seen, 0);
        if (rmode == 0 && vmode == 0) check("back_to_back", last_out - first_out, n - 1);
        @(negedge clk);
        check("done_single", done, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        cfg_width   = '0;
        cfg_height  = '0;
        cfg_channel = '0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b0;
        @(negedge clk);
        check("reset_outputs", {s_ready, m_valid, m_data, m_sof, m_eol, m_eof, busy, done, err}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_s_ready", s_ready, 0);

        run_frame(2, 2, 3, 0, 0, 1, -1, 1'b0);
        run_frame(2, 2, 3, 1, 0, 1, -1, 1'b0);
        run_frame(1, 1, 4, 0, 0, 2, -1, 1'b0);

        bad_start("width_zero", 0, 2, 3);
        bad_start("channel_five", 2, 2, 5);
        bad_start("height_zero", 3, 0, 1);
        bad_start("width_over_max", 4097, 1, 1);
        bad_start("channel_zero", 1, 1, 0);

        run_frame(4, 4, 1, 0, 0, 1, 7, 1'b0);
        run_frame(4, 4, 1, 0, 0, 1, -1, 1'b0);
        run_frame(3, 2, 2, 2, 1, 0, -1, 1'b1);

        for (int f = 0; f < 10; f++) begin
            run_frame($urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(1, 4), 2, 1, 0, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
